// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares one FIFO write port among NUM_REQ
// valid/ready producers. A grant lasts at most MAX_BURST transfers and is
// always followed by one IDLE arbitration cycle. Back-pressure comes from the
// downstream FIFO full flag, which is registered in the FIFO, so a write can
// never coincide with the cycle the FIFO becomes full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic                          grant_valid_o,
    output logic [ID_W-1:0]               grant_id_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // After reset the last owner is the highest index, so producer 0 wins first.
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_e           state_q;
    logic [ID_W-1:0]  owner_q;
    logic [ID_W-1:0]  last_q;
    logic [CNT_W-1:0] burst_cnt_q;
    logic             grant_valid_q;

    logic                  in_grant_s;
    logic                  owner_valid_s;
    logic [DATA_WIDTH-1:0] owner_data_s;
    logic                  xfer_s;
    logic                  burst_last_s;
    logic                  pick_found_s;
    logic [ID_W-1:0]       pick_idx_s;

    // Index reached by stepping 'step' places past 'base', wrapping at NUM_REQ.
    // base < NUM_REQ and step <= NUM_REQ, so a single subtraction suffices.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int              step);
        int sum;
        sum = int'(base) + step;
        sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
        return ID_W'(sum);
    endfunction

    assign in_grant_s   = (state_q == ST_GRANT);
    assign burst_last_s = (burst_cnt_q == CNT_LAST);

    // Round-robin search: first valid producer after the last released owner.
    always_comb begin
        logic [ID_W-1:0] cand_v;
        logic            hit_v;
        pick_found_s = 1'b0;
        pick_idx_s   = {ID_W{1'b0}};
        cand_v       = {ID_W{1'b0}};
        hit_v        = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_v       = rr_index(last_q, i);
            hit_v        = !pick_found_s && req_valid_i[cand_v];
            pick_idx_s   = hit_v ? cand_v : pick_idx_s;
            pick_found_s = pick_found_s | hit_v;
        end
    end

    // Select the owner's valid bit and data word with an AND-OR mux.
    always_comb begin
        owner_valid_s = 1'b0;
        owner_data_s  = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_valid_s = owner_valid_s | (req_valid_i[i] & (owner_q == ID_W'(i)));
            owner_data_s  = owner_data_s
                          | (req_data_i[i*DATA_WIDTH +: DATA_WIDTH]
                             & {DATA_WIDTH{owner_q == ID_W'(i)}});
        end
    end

    // A transfer needs the owner's word and room in the FIFO.
    assign xfer_s = in_grant_s & owner_valid_s & ~fifo_full_i;

    // Ready goes only to the owner and never depends on req_valid_i.
    always_comb begin
        req_ready_o = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = in_grant_s & (owner_q == ID_W'(i)) & ~fifo_full_i;
        end
    end

    // FIFO write port: data is forced to zero whenever no write is issued.
    always_comb begin
        fifo_wr_en_o = xfer_s;
        if (xfer_s) begin
            fifo_wr_data_o = owner_data_s;
        end else begin
            fifo_wr_data_o = {DATA_WIDTH{1'b0}};
        end
    end

    // Arbitration FSM: IDLE picks an owner, GRANT runs the bounded burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= {ID_W{1'b0}};
            last_q        <= LAST_RST;
            burst_cnt_q   <= {CNT_W{1'b0}};
            grant_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        owner_q       <= pick_idx_s;
                        burst_cnt_q   <= {CNT_W{1'b0}};
                        state_q       <= ST_GRANT;
                        grant_valid_q <= 1'b1;
                    end else begin
                        state_q       <= ST_IDLE;
                        grant_valid_q <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!owner_valid_s) begin
                        // Owner withdrew: release without a transfer.
                        last_q        <= owner_q;
                        burst_cnt_q   <= {CNT_W{1'b0}};
                        state_q       <= ST_IDLE;
                        grant_valid_q <= 1'b0;
                    end else if (xfer_s) begin
                        if (burst_last_s) begin
                            last_q        <= owner_q;
                            burst_cnt_q   <= {CNT_W{1'b0}};
                            state_q       <= ST_IDLE;
                            grant_valid_q <= 1'b0;
                        end else begin
                            burst_cnt_q   <= burst_cnt_q + CNT_W'(1);
                            state_q       <= ST_GRANT;
                            grant_valid_q <= 1'b1;
                        end
                    end else begin
                        // FIFO full with the owner still valid: hold everything.
                        state_q       <= ST_GRANT;
                        grant_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_valid_o = grant_valid_q;
    assign grant_id_o    = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4)
// with a behavioural 16-deep FIFO on the write side.
module tb_fifo_wr_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          fifo_full;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          grant_valid;
    logic [1:0]    grant_id;

    logic          force_full;
    logic          rd_en;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .fifo_full_i    (fifo_full),
        .fifo_wr_en_o   (wr_en),
        .fifo_wr_data_o (wr_data),
        .grant_valid_o  (grant_valid),
        .grant_id_o     (grant_id)
    );

    // Behavioural FIFO: full comes from the registered count
    logic [DW-1:0] mem [DEPTH];
    logic [4:0]    f_cnt;
    logic [3:0]    f_wp, f_rp;
    logic          m_wr, m_rd;
    logic [DW-1:0] popped [$];

    assign fifo_full = force_full | (f_cnt == 5'd16);
    assign m_wr      = wr_en && (f_cnt != 5'd16);
    assign m_rd      = rd_en && (f_cnt != 5'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt <= 5'd0;
            f_wp  <= 4'd0;
            f_rp  <= 4'd0;
        end else begin
            if (m_wr) begin
                mem[f_wp] <= wr_data;
                f_wp      <= f_wp + 4'd1;
            end
            if (m_rd) begin
                popped.push_back(mem[f_rp]);
                f_rp <= f_rp + 4'd1;
            end
            f_cnt <= f_cnt + {4'd0, m_wr} - {4'd0, m_rd};
        end
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        req_data   = 32'h0;
        force_full = 1'b0;
        rd_en      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_rdy;
        logic [7:0] exp_d;
        int         exp_id;
        int         hold_id;
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        force_full = 1'b0;
        rd_en      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL reset.grant_valid: got %b expected 0", grant_valid); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset.grant_id: got %0d expected 0", grant_id); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset.req_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset.wr_en: got %b expected 0", wr_en); end
        n_cmp++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset.wr_data: got %h expected 00", wr_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Grant order 0,1,2,3,0; four writes each, one idle cycle before each grant
        for (int g = 0; g < 5; g++) begin
            exp_id  = g % 4;
            hold_id = (g == 0) ? 0 : (g - 1) % 4;
            exp_rdy = 4'b0001 << exp_id;
            exp_d   = 8'hC0 | 8'(exp_id);
            @(negedge clk);
            n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rr.idle_gv g=%0d: got %b expected 0", g, grant_valid); end
            n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rr.idle_wr g=%0d: got %b expected 0", g, wr_en); end
            n_cmp++; if (grant_id !== 2'(hold_id)) begin n_err++; $display("FAIL rr.idle_hold_id g=%0d: got %0d expected %0d", g, grant_id, hold_id); end
            @(posedge clk); #1;
            for (int k = 0; k < MB; k++) begin
                @(negedge clk);
                n_cmp++; if (grant_valid !== 1'b1) begin n_err++; $display("FAIL rr.gv g=%0d k=%0d: got %b expected 1", g, k, grant_valid); end
                n_cmp++; if (grant_id !== 2'(exp_id)) begin n_err++; $display("FAIL rr.id g=%0d k=%0d: got %0d expected %0d", g, k, grant_id, exp_id); end
                n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL rr.wr_en g=%0d k=%0d: got %b expected 1", g, k, wr_en); end
                n_cmp++; if (wr_data !== exp_d) begin n_err++; $display("FAIL rr.wr_data g=%0d k=%0d: got %h expected %h", g, k, wr_data, exp_d); end
                n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr.ready g=%0d k=%0d: got %b expected %b", g, k, req_ready, exp_rdy); end
                @(posedge clk); #1;
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_short_burst();
        do_reset();
        req_valid        = 4'b0100;
        req_data[23:16]  = 8'hA1;
        @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL short.idle_gv: got %b expected 0", grant_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL short.id: got %0d expected 2", grant_id); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL short.ready: got %b expected 0100", req_ready); end
        n_cmp++; if (wr_data !== 8'hA1 || wr_en !== 1'b1) begin n_err++; $display("FAIL short.word1: got en=%b data=%h expected en=1 data=a1", wr_en, wr_data); end
        @(posedge clk); #1;
        req_data[23:16] = 8'hA2;
        @(negedge clk);
        n_cmp++; if (wr_data !== 8'hA2 || wr_en !== 1'b1) begin n_err++; $display("FAIL short.word2: got en=%b data=%h expected en=1 data=a2", wr_en, wr_data); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b1) begin n_err++; $display("FAIL short.drop_gv: got %b expected 1", grant_valid); end
        n_cmp++; if (wr_en !== 1'b0 || wr_data !== 8'h00) begin n_err++; $display("FAIL short.drop_wr: got en=%b data=%h expected en=0 data=00", wr_en, wr_data); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL short.released: got %b expected 0", grant_valid); end
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL short.hold_id: got %0d expected 2", grant_id); end
        @(posedge clk); #1;
        // last = 2, so with producers 2 and 3 both valid the search picks 3
        req_valid = 4'b1100;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (grant_id !== 2'd3 || grant_valid !== 1'b1) begin n_err++; $display("FAIL short.last_is_2: got gv=%b id=%0d expected gv=1 id=3", grant_valid, grant_id); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid       = 4'b0010;
        req_data[15:8]  = 8'h50;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b1 || wr_data !== 8'h50 || grant_id !== 2'd1) begin n_err++; $display("FAIL stall.w1: got en=%b data=%h id=%0d expected en=1 data=50 id=1", wr_en, wr_data, grant_id); end
        @(posedge clk); #1;
        req_data[15:8] = 8'h51;
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b1 || wr_data !== 8'h51) begin n_err++; $display("FAIL stall.w2: got en=%b data=%h expected en=1 data=51", wr_en, wr_data); end
        @(posedge clk); #1;
        req_data[15:8] = 8'h52;
        force_full     = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_cmp++; if (wr_en !== 1'b0 || wr_data !== 8'h00) begin n_err++; $display("FAIL stall.wr s=%0d: got en=%b data=%h expected en=0 data=00", s, wr_en, wr_data); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall.ready s=%0d: got %b expected 0000", s, req_ready); end
            n_cmp++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin n_err++; $display("FAIL stall.hold s=%0d: got gv=%b id=%0d expected gv=1 id=1", s, grant_valid, grant_id); end
            @(posedge clk); #1;
        end
        force_full = 1'b0;
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b1 || wr_data !== 8'h52 || req_ready !== 4'b0010) begin n_err++; $display("FAIL stall.w3: got en=%b data=%h rdy=%b expected en=1 data=52 rdy=0010", wr_en, wr_data, req_ready); end
        @(posedge clk); #1;
        req_data[15:8] = 8'h53;
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b1 || wr_data !== 8'h53) begin n_err++; $display("FAIL stall.w4: got en=%b data=%h expected en=1 data=53", wr_en, wr_data); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b0 || wr_en !== 1'b0) begin n_err++; $display("FAIL stall.release_after_4: got gv=%b en=%b expected gv=0 en=0", grant_valid, wr_en); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid       = 4'b0001;
        req_data[7:0]   = 8'h0F;
        req_data[31:24] = 8'h3C;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (grant_id !== 2'd0 || wr_en !== 1'b1) begin n_err++; $display("FAIL fair.first: got id=%0d en=%b expected id=0 en=1", grant_id, wr_en); end
        @(posedge clk); #1;
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (grant_id !== 2'd0 || req_ready !== 4'b0001 || wr_data !== 8'h0F) begin n_err++; $display("FAIL fair.p0_keeps k=%0d: got id=%0d rdy=%b data=%h expected id=0 rdy=0001 data=0f", k, grant_id, req_ready, wr_data); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL fair.idle: got %b expected 0", grant_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin n_err++; $display("FAIL fair.p3_next: got gv=%b id=%0d expected gv=1 id=3", grant_valid, grant_id); end
        n_cmp++; if (wr_data !== 8'h3C || req_ready !== 4'b1000) begin n_err++; $display("FAIL fair.p3_data: got data=%h rdy=%b expected data=3c rdy=1000", wr_data, req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++; if (grant_id !== 2'd3 || wr_en !== 1'b0) begin n_err++; $display("FAIL fair.p3_drop: got id=%0d en=%b expected id=3 en=0", grant_id, wr_en); end
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin n_err++; $display("FAIL fair.wrap_to_0: got gv=%b id=%0d expected gv=1 id=0", grant_valid, grant_id); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid       = 4'b0100;
        req_data[23:16] = 8'h77;
        req_data[7:0]   = 8'h0A;
        @(negedge clk);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++; if (wr_en !== 1'b1 || wr_data !== 8'h77) begin n_err++; $display("FAIL midrst.pre k=%0d: got en=%b data=%h expected en=1 data=77", k, wr_en, wr_data); end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin n_err++; $display("FAIL midrst.grant: got gv=%b id=%0d expected gv=0 id=0", grant_valid, grant_id); end
        n_cmp++; if (wr_en !== 1'b0 || wr_data !== 8'h00 || req_ready !== 4'b0000) begin n_err++; $display("FAIL midrst.port: got en=%b data=%h rdy=%b expected en=0 data=00 rdy=0000", wr_en, wr_data, req_ready); end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b0101;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (grant_valid !== 1'b1 || grant_id !== 2'd0 || wr_data !== 8'h0A) begin n_err++; $display("FAIL midrst.next_p0: got gv=%b id=%0d data=%h expected gv=1 id=0 data=0a", grant_valid, grant_id, wr_data); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
    endtask

    task automatic test_back_to_back();
        int  ptr [NR];
        int  exp_k [NR];
        bit  xf [NR];
        int  cyc;
        int  src;
        bit  done;
        logic [7:0] w;
        do_reset();
        popped.delete();
        for (int p = 0; p < NR; p++) begin ptr[p] = 0; exp_k[p] = 0; end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 2000) begin
            for (int p = 0; p < NR; p++) begin
                req_valid[p]         = (ptr[p] < 8);
                req_data[p*DW +: DW] = 8'(p * 16 + ptr[p]);
            end
            rd_en = (cyc % 3 == 0);
            @(negedge clk);
            n_cmp++; if (!$onehot0(req_ready)) begin n_err++; $display("FAIL e2e.ready_onehot cyc=%0d: got %b expected at most one bit", cyc, req_ready); end
            src = -1;
            for (int p = 0; p < NR; p++) begin
                xf[p] = req_ready[p] && req_valid[p];
                if (xf[p]) src = p;
            end
            if (wr_en === 1'b1) begin
                n_cmp++;
                if (src < 0) begin
                    n_err++; $display("FAIL e2e.wr_no_owner cyc=%0d: got wr_en=1 expected a ready&valid producer", cyc);
                end else if (wr_data !== 8'(src * 16 + ptr[src])) begin
                    n_err++; $display("FAIL e2e.wr_data cyc=%0d: got %h expected %h", cyc, wr_data, 8'(src * 16 + ptr[src]));
                end
            end
            @(posedge clk); #1;
            for (int p = 0; p < NR; p++) if (xf[p]) ptr[p]++;
            cyc++;
            done = (ptr[0] == 8) && (ptr[1] == 8) && (ptr[2] == 8) && (ptr[3] == 8) && (f_cnt == 5'd0);
        end
        req_valid = 4'b0000;
        rd_en     = 1'b1;
        n_cmp++; if (!done) begin n_err++; $display("FAIL e2e.timeout: got done=0 after %0d cycles expected done=1", cyc); end
        n_cmp++; if (popped.size() != 32) begin n_err++; $display("FAIL e2e.count: got %0d words expected 32", popped.size()); end
        foreach (popped[i]) begin
            w = popped[i];
            n_cmp++;
            if (w[7:4] >= 4'd4) begin
                n_err++; $display("FAIL e2e.word_tag i=%0d: got %h expected producer 0..3", i, w);
            end else if (int'(w[3:0]) != exp_k[w[7:4]]) begin
                n_err++; $display("FAIL e2e.order i=%0d: got %h expected index %0d", i, w, exp_k[w[7:4]]);
            end
            if (w[7:4] < 4'd4) exp_k[w[7:4]]++;
        end
        for (int p = 0; p < NR; p++) begin
            n_cmp++; if (exp_k[p] != 8) begin n_err++; $display("FAIL e2e.per_prod p=%0d: got %0d expected 8", p, exp_k[p]); end
        end
    endtask

    initial begin
        req_valid  = 4'b0000;
        req_data   = 32'h0;
        force_full = 1'b0;
        rd_en      = 1'b1;
        rst_n      = 1'b0;
        test_reset();
        test_short_burst();
        test_full_stall();
        test_fairness();
        test_reset_mid_burst();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1);
    end

endmodule
